rgb_led_sequencer: RTL and testbench

Programmable colour sequencer that drives the 8-bit colour inputs of the RGB PWM LED controller. It holds a small palette of colour and hold-time entries and steps through them, with optional linear cross-fades, advancing only on the PWM driver's start-of-cycle pulse. It sits between a register/CPU write port and the PWM driver, so a colour change never lands mid-PWM-period.

---
 rtl/rgb_led_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: steps the RGB PWM driver's colour inputs through a small palette of
//   colour/hold entries, optionally cross-fading, advancing only on the driver's frame pulse.
// Latency: start -> LOAD on the next edge; colour updates land one clk after the sync_i cycle
//   (or on the LOAD edge when fades are compiled out). No backpressure: start while busy is dropped.
// Ports:
//   clk, rst          system clock (shared with the PWM driver), async active-high reset
//   sync_i            PWM start-of-cycle pulse, one clk wide per frame
//   start, stop, loop sequence control (stop wins over start), loop level selects wrap vs finish
//   len               number of active entries, latched at start, clamped to ENTRIES
//   wr_en/wr_addr/wr_color/wr_hold  palette write port, accepted in every state
//   rcolor_o/gcolor_o/bcolor_o      registered colour to the PWM driver
//   idx_o, busy, done current entry, not-idle flag, completion pulse
// Build option: RGB_SEQ_FADE_EN adds the FADE state (1 LSB per frame linear ramps);
//   without it LOAD writes the target colour straight to the outputs.
module rgb_led_sequencer #(
    parameter int  ENTRIES = 8,
    parameter int  HOLD_W  = 8,
    localparam int AW      = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_i,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [AW:0]       len,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [23:0]       wr_color,
    input  logic [HOLD_W-1:0] wr_hold,
    output logic [7:0]        rcolor_o,
    output logic [7:0]        gcolor_o,
    output logic [7:0]        bcolor_o,
    output logic [AW-1:0]     idx_o,
    output logic              busy,
    output logic              done
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(ENTRIES);

`ifdef RGB_SEQ_FADE_EN
    typedef enum logic [1:0] {IDLE, LOAD, FADE, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
`endif

    // ------------------------------------------------------------------
    // Palette storage. Deliberately unreset: software must program an
    // entry before the sequencer is pointed at it.
    // ------------------------------------------------------------------
    logic [23:0]       pal_color [ENTRIES];
    logic [HOLD_W-1:0] pal_hold  [ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pal_color[wr_addr] <= wr_color;
            pal_hold[wr_addr]  <= wr_hold;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            state,    state_n;
    logic [AW-1:0]     idx,      idx_n;
    logic [AW:0]       len_q,    len_n;
    logic [23:0]       color,    color_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              done_q,   done_n;
    logic [AW:0]       idx_inc;

    // Widened so that idx+1 == len_q is representable when idx is the last entry.
    assign idx_inc = {1'b0, idx} + (AW+1)'(1);

`ifdef RGB_SEQ_FADE_EN
    logic [23:0] tgt, tgt_n;
    logic [23:0] stepped;

    // One LSB toward the target; equal channels stay put, so a channel can
    // never overshoot its target.
    function automatic logic [7:0] step_chan(input logic [7:0] cur, input logic [7:0] goal);
        logic [7:0] res;
        res = cur;
        if (cur < goal) begin
            res = cur + 8'd1;
        end else if (cur > goal) begin
            res = cur - 8'd1;
        end
        return res;
    endfunction

    assign stepped = {step_chan(color[23:16], tgt[23:16]),
                      step_chan(color[15:8],  tgt[15:8]),
                      step_chan(color[7:0],   tgt[7:0])};
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len_q;
        color_n = color;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
`ifdef RGB_SEQ_FADE_EN
        tgt_n   = tgt;
`endif
        if (stop) begin
            // Abort freezes colour, index and counters; only the state moves.
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        idx_n   = '0;
                        len_n   = (len > LEN_MAX) ? LEN_MAX : len;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    // The hold count is captured here; in fade builds it then
                    // sits untouched through FADE until HOLD starts using it.
                    hold_n = pal_hold[idx];
`ifdef RGB_SEQ_FADE_EN
                    tgt_n   = pal_color[idx];
                    state_n = FADE;
`else
                    color_n = pal_color[idx];
                    state_n = HOLD;
`endif
                end
`ifdef RGB_SEQ_FADE_EN
                FADE: begin
                    if (sync_i) begin
                        color_n = stepped;
                        // An entry whose target already matches still spends
                        // one frame here before entering HOLD.
                        if (stepped == tgt) begin
                            state_n = HOLD;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (sync_i) begin
                        if (hold_cnt != '0) begin
                            hold_n = hold_cnt - HOLD_W'(1);
                        end else if (idx_inc < len_q) begin
                            idx_n   = idx_inc[AW-1:0];
                            state_n = LOAD;
                        end else if (loop) begin
                            idx_n   = '0;
                            state_n = LOAD;
                        end else begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            len_q    <= '0;
            color    <= '0;
            hold_cnt <= '0;
            done_q   <= 1'b0;
`ifdef RGB_SEQ_FADE_EN
            tgt      <= '0;
`endif
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len_q    <= len_n;
            color    <= color_n;
            hold_cnt <= hold_n;
            done_q   <= done_n;
`ifdef RGB_SEQ_FADE_EN
            tgt      <= tgt_n;
`endif
        end
    end

    assign rcolor_o = color[23:16];
    assign gcolor_o = color[15:8];
    assign bcolor_o = color[7:0];
    assign idx_o    = idx;
    assign busy     = (state != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: directed stimulus with an event scoreboard on the sequencer outputs.
// Every change of {busy, done, idx, colour} seen on the falling edge must match the next
// expected event queued by the stimulus; point checks cover reset and edge timing.
module tb_rgb_led_sequencer;

    localparam int ENTRIES = 8;
    localparam int HOLD_W  = 8;
    localparam int AW      = 3;

    typedef logic [28:0] obs_t;   // {busy, done, idx[2:0], r, g, b}

    logic              clk = 1'b0;
    logic              rst;
    logic              sync_i;
    logic              start;
    logic              stop;
    logic              loop;
    logic [AW:0]       len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [23:0]       wr_color;
    logic [HOLD_W-1:0] wr_hold;
    logic [7:0]        rcolor_o;
    logic [7:0]        gcolor_o;
    logic [7:0]        bcolor_o;
    logic [AW-1:0]     idx_o;
    logic              busy;
    logic              done;

    rgb_led_sequencer #(.ENTRIES(ENTRIES), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync_i   (sync_i),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .len      (len),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_color (wr_color),
        .wr_hold  (wr_hold),
        .rcolor_o (rcolor_o),
        .gcolor_o (gcolor_o),
        .bcolor_o (bcolor_o),
        .idx_o    (idx_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    obs_t exp_q[$];
    obs_t prev_obs = '0;
    obs_t cur_obs;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output-change monitor: each change pops one scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_obs = {busy, done, idx_o, rcolor_o, gcolor_o, bcolor_o};
            if (cur_obs != prev_obs) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", cur_obs, prev_obs);
                end else begin
                    chk("evt", cur_obs, exp_q.pop_front());
                end
                prev_obs = cur_obs;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic b, input logic d, input logic [AW-1:0] i,
                              input logic [23:0] c);
        exp_q.push_back({b, d, i, c});
    endtask

    task automatic pal_wr(input int addr, input logic [23:0] c, input int h);
        wr_en    = 1'b1;
        wr_addr  = AW'(addr);
        wr_color = c;
        wr_hold  = HOLD_W'(h);
        tick(1);
        wr_en    = 1'b0;
    endtask

    task automatic do_sync();
        sync_i = 1'b1;
        tick(1);
        sync_i = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [23:0] col(input int i);
        logic [7:0] r, g, b;
        r = 8'(i * 16 + 1);
        g = 8'(i);
        b = 8'(255 - i);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] rgb_now();
        return {rcolor_o, gcolor_o, bcolor_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sync_i = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        len = '0; wr_en = 1'b0; wr_addr = '0; wr_color = '0; wr_hold = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("rst_r", rcolor_o, 0);
        chk("rst_g", gcolor_o, 0);
        chk("rst_b", bcolor_o, 0);
        chk("rst_idx", idx_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        mon_en = 1'b1;

        // start with len==0 is ignored
        len = '0;
        pulse_start();
        tick(2);
        chk("len0_ignored", busy, 0);

`ifdef RGB_SEQ_FADE_EN
        // Ramp from black to {10,00,05}, hold 2
        pal_wr(0, 24'h100005, 2);
        len = 1; loop = 1'b0;
        expect_evt(1, 0, 0, 24'h000000);
        pulse_start();
        chk("f_busy_load", busy, 1);
        tick(1);
        for (int k = 1; k <= 16; k++) begin
            expect_evt(1, 0, 0, {8'(k), 8'h00, 8'((k < 5) ? k : 5)});
            do_sync();
            tick(2);
        end
        for (int h = 0; h < 3; h++) begin
            if (h == 2) begin
                expect_evt(0, 1, 0, 24'h100005);
                expect_evt(0, 0, 0, 24'h100005);
            end
            do_sync();
            if (h < 2) begin
                chk("f_hold_busy", busy, 1);
            end else begin
                chk("f_done", done, 1);
                chk("f_busy_fall", busy, 0);
                tick(1);
                chk("f_done_one_cycle", done, 0);
            end
            tick(2);
        end
        chk("f_final_col", rgb_now(), 24'h100005);
`else
        // Single entry, no loop: direct load, hold+1 frames, done
        pal_wr(0, 24'h100005, 2);
        len = 1; loop = 1'b0;
        expect_evt(1, 0, 0, 24'h000000);
        expect_evt(1, 0, 0, 24'h100005);
        pulse_start();
        chk("a_busy_t1", busy, 1);
        chk("a_col_t1", rgb_now(), 24'h000000);
        tick(1);
        chk("a_col_t2", rgb_now(), 24'h100005);
        tick(2);
        for (int h = 0; h < 3; h++) begin
            if (h == 2) begin
                expect_evt(0, 1, 0, 24'h100005);
                expect_evt(0, 0, 0, 24'h100005);
            end
            do_sync();
            if (h < 2) begin
                chk("a_hold_busy", busy, 1);
            end else begin
                chk("a_done", done, 1);
                chk("a_busy_fall", busy, 0);
                tick(1);
                chk("a_done_one_cycle", done, 0);
            end
            tick(2);
        end
        chk("a_final_col", rgb_now(), 24'h100005);

        // Looping two-entry sequence with a write to the displayed entry
        pal_wr(0, 24'hFF0000, 0);
        pal_wr(1, 24'h0000FF, 0);
        len = 2; loop = 1'b1;
        expect_evt(1, 0, 0, 24'h100005);
        expect_evt(1, 0, 0, 24'hFF0000);
        pulse_start();
        tick(3);
        expect_evt(1, 0, 1, 24'hFF0000);
        expect_evt(1, 0, 1, 24'h0000FF);
        do_sync();
        chk("b_idx1", idx_o, 1);
        chk("b_col_at_sync", rgb_now(), 24'hFF0000);
        tick(1);
        chk("b_col_entry1", rgb_now(), 24'h0000FF);
        tick(2);
        expect_evt(1, 0, 0, 24'h0000FF);
        expect_evt(1, 0, 0, 24'hFF0000);
        do_sync();
        chk("b_idx_wrap", idx_o, 0);
        tick(3);
        pal_wr(0, 24'h00FF00, 0);
        tick(2);
        chk("b_wr_no_effect", rgb_now(), 24'hFF0000);
        expect_evt(1, 0, 1, 24'hFF0000);
        expect_evt(1, 0, 1, 24'h0000FF);
        do_sync();
        tick(3);
        expect_evt(1, 0, 0, 24'h0000FF);
        expect_evt(1, 0, 0, 24'h00FF00);
        do_sync();
        tick(1);
        chk("b_new_entry0", rgb_now(), 24'h00FF00);
        chk("b_still_busy", busy, 1);
        tick(2);

        // stop and start together in HOLD: stop wins, colour frozen, no done
        expect_evt(0, 0, 0, 24'h00FF00);
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("c_busy", busy, 0);
        chk("c_done", done, 0);
        chk("c_col_frozen", rgb_now(), 24'h00FF00);
        tick(3);
        chk("c_start_ignored", busy, 0);

        // len above ENTRIES clamps to a full 8-entry pass
        for (int i = 0; i < ENTRIES; i++) pal_wr(i, col(i), 0);
        len = 15; loop = 1'b0;
        expect_evt(1, 0, 0, 24'h00FF00);
        expect_evt(1, 0, 0, col(0));
        pulse_start();
        tick(3);
        for (int k = 1; k < ENTRIES; k++) begin
            expect_evt(1, 0, AW'(k), col(k - 1));
            expect_evt(1, 0, AW'(k), col(k));
            do_sync();
            tick(3);
        end
        expect_evt(0, 1, 7, col(7));
        expect_evt(0, 0, 7, col(7));
        do_sync();
        chk("d_done", done, 1);
        chk("d_idx_last", idx_o, 7);
        tick(3);
`endif
        chk("evt_q_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a running sequence
        mon_en = 1'b0;
        pal_wr(0, 24'h204060, 3);
        len = 1; loop = 1'b1;
        pulse_start();
        tick(3);
        do_sync();
        tick(2);
        do_sync();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_col_nz", (rgb_now() != 24'h0), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_col", rgb_now(), 24'h0);
        chk("arst_idx", idx_o, 0);
        chk("arst_done", done, 0);
        tick(2);
        rst = 1'b0;
        prev_obs = '0;
        mon_en = 1'b1;
        tick(4);
        chk("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
